decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipelined Y86-64 decode stage, directly downstream of the fetch stage. Holds the D pipeline register (captures fetch outputs each cycle, with stall/bubble control) and the 15-entry architectural register file. Derives source and destination register IDs and produces forwarded operands valA/valB for the execute stage.

Parameters:
RSP_INIT, 64'h0, reset value of %rsp (reg 4); used only when RSP_RESET_EN is defined.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
f_icode  in  4  fetched icode
f_ifun  in  4  fetched ifun
f_rA  in  4  fetched rA
f_rB  in  4  fetched rB
f_valC  in  64  fetched constant
f_valP  in  64  fetched next-PC
f_stat  in  3  fetch status: AOK=1, HLT=2, ADR=3, INS=4
D_stall  in  1  hold D register
D_bubble  in  1  load NOP bubble into D register
e_dstE  in  4  / e_valE in 64: execute-stage forward source
M_dstE  in  4  / M_valE in 64: memory-register forward source
M_dstM  in  4  / m_valM in 64: memory-stage read forward source
W_dstE  in  4  / W_valE in 64: writeback port E, also forward source
W_dstM  in  4  / W_valM in 64: writeback port M, also forward source
D_icode, D_ifun, D_stat, D_valC, D_valP  out  4,4,3,64,64  D register contents
d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs (4'hF = none)
d_valA, d_valB  out  64 each  forwarded operands

Behaviour:
- Reset (async, rst_n low): D register = bubble: icode 4'h1 (nop), ifun 0, rA=rB=4'hF, valC=0, valP=0, stat AOK. All 15 registers = 0.
- D register update at posedge clk: D_stall=1 -> hold; else D_bubble=1 -> bubble values; else capture f_* inputs. If both are asserted, stall wins.
- Register file:
  - written at posedge clk from W_dstE/W_valE and W_dstM/W_valM; ID 4'hF means no write.
  - If W_dstE==W_dstM (not F), W_valM is written.
  - Reads are combinational; ID 4'hF reads 0.
- ID decode (combinational, from D register):
  - srcA: rA for cmov/rmmov/opq/push; 4 for pop/ret; else F.
  - srcB: rB for opq/rmmov/mrmov; 4 for push/pop/call/ret; else F.
  - dstE: rB for cmov/irmov/opq; 4 for push/pop/call/ret; else F.
  - dstM: rA for mrmov/pop; else F.
- d_valA priority:
  1. D_valP if D_icode is call (8) or jXX (7).
  2. Else forward by first match of d_srcA (srcA != F) in this order: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE.
  3. Else register file.
- d_valB: same forwarding order on d_srcB, without the valP rule.
- A source ID of 4'hF never matches any forward; d_val = 0.
- Forwarding from W covers same-cycle write/read; no internal bypass is needed.
- Zero latency through decode logic; one cycle through the D register.
- Reset mid-operation: the D register and register file clear immediately, independent of the clock.

Optional Feature:
RSP_RESET_EN: when defined, register 4 (%rsp) resets to RSP_INIT; all other registers reset to 0. When undefined, all registers reset to 0 and RSP_INIT is ignored.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT..POPQ.
  - register IDs: RRSP=4, RNONE=4'hF.
  - status codes: AOK/HLT/ADR/INS.
  - bubble-value constants.
- One natural sub-module, regfile_2w2r: 15x64 register file with 2 combinational read ports, 2 synchronous write ports, and async reset. Forwarding mux and D register remain in decode_stage.

Test Plan:
- Reset then idle: D_icode=1, d_srcA=d_srcB=F, d_valA=d_valB=0. With RSP_RESET_EN and RSP_INIT=0x100, a pop in D gives d_valB=0x100.
- Write W_dstE=2, W_valE=0x626; next cycle D holds rrmovq %rdx,%rax (20 20) -> d_srcA=2, d_valA=0x626 from regfile.
- D holds opq rA=1 with e_dstE=1 e_valE=5, M_dstE=1 M_valE=7 -> d_valA=5 (execute priority). Drop e_dstE to F -> d_valA=7.
- Same-cycle W_dstE=3 val 9 and W_dstM=3 val 11 -> register 3 reads 11 afterwards. Meanwhile a reader of reg 3 that cycle gets 11 via the W_dstM forward.
- Call with valP=0x20 in D -> d_valA=0x20, d_srcB=4, d_dstE=4 regardless of forwards.
- D_stall=1 holds the D register across a changing f_icode. D_bubble=1 loads nop/AOK. Both asserted -> hold. rst_n low mid-cycle clears asynchronously.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode slice.
// Contents: instruction codes, register IDs, status codes, the D pipeline
// register layout and its bubble (nop) value.
package y86_pkg;

  localparam int DATA_W = 64;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register IDs
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [DATA_W-1:0] valc;
    logic [DATA_W-1:0] valp;
    logic [2:0]        stat;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  '0,
    valp:  '0,
    stat:  S_AOK
  };

endpackage

// File: rtl/regfile_2w2r.sv
// 15 x 64-bit Y86-64 architectural register file.
// Ports: clk, rst_n (async active-low); src_a/src_b -> val_a/val_b are
// combinational reads (ID 4'hF reads 0); dst_e/val_e and dst_m/val_m are
// synchronous writes (ID 4'hF = no write; port M wins on an ID clash).
// Optional macro RSP_RESET_EN: when defined, %rsp resets to RSP_INIT.
module regfile_2w2r
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

`ifdef RSP_RESET_EN
  localparam logic RSP_EN = 1'b1;
`else
  localparam logic RSP_EN = 1'b0;
`endif

  // Masking keeps RSP_INIT referenced even when the feature is off.
  localparam logic [63:0] RSP_RST = RSP_INIT & {64{RSP_EN}};

  logic [63:0] regs [15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_RST : 64'h0;
      end
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      // Issued after port E so that M takes precedence on a shared ID.
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  assign val_a = (src_a == RNONE) ? 64'h0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? 64'h0 : regs[src_b];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 pipelined decode stage.
// Holds the D pipeline register (stall/bubble controlled) and the register
// file; derives srcA/srcB/dstE/dstM and forwards valA/valB for execute.
// Ports: clk, rst_n (async active-low); f_* fetch outputs; D_stall,
// D_bubble; forward sources e_*, M_*, m_valM, W_* (W_* also write the
// register file); D_* register contents; d_src*/d_dst* IDs; d_valA/d_valB.
// Optional macro RSP_RESET_EN: when defined, %rsp resets to RSP_INIT.
module decode_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [2:0]  f_stat,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [2:0]  D_stat,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);

  d_reg_t      d_p0;
  logic [63:0] rf_a;
  logic [63:0] rf_b;

  // Forwarding priority: newest producer first.
  function automatic logic [63:0] fwd_sel(
    input logic [3:0]  src,
    input logic [63:0] rf_val,
    input logic [3:0]  ed,  input logic [63:0] ev,
    input logic [3:0]  mm,  input logic [63:0] mv,
    input logic [3:0]  me,  input logic [63:0] mev,
    input logic [3:0]  wm,  input logic [63:0] wmv,
    input logic [3:0]  we,  input logic [63:0] wev
  );
    logic [63:0] r;
    r = rf_val;
    if (src == RNONE)   r = 64'h0;
    else if (src == ed) r = ev;
    else if (src == mm) r = mv;
    else if (src == me) r = mev;
    else if (src == wm) r = wmv;
    else if (src == we) r = wev;
    return r;
  endfunction

  // ---- Stage boundary: fetch -> D register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_p0 <= D_BUBBLE;
    end else if (D_stall) begin
      d_p0 <= d_p0;
    end else if (D_bubble) begin
      d_p0 <= D_BUBBLE;
    end else begin
      d_p0 <= '{icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                valc: f_valC, valp: f_valP, stat: f_stat};
    end
  end

  assign D_icode = d_p0.icode;
  assign D_ifun  = d_p0.ifun;
  assign D_stat  = d_p0.stat;
  assign D_valC  = d_p0.valc;
  assign D_valP  = d_p0.valp;

  // ---- Decode logic (combinational from D register) ----
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (d_p0.icode)
      I_RRMOVQ: begin d_srcA = d_p0.ra; d_dstE = d_p0.rb; end
      I_IRMOVQ: begin d_dstE = d_p0.rb; end
      I_RMMOVQ: begin d_srcA = d_p0.ra; d_srcB = d_p0.rb; end
      I_MRMOVQ: begin d_srcB = d_p0.rb; d_dstM = d_p0.ra; end
      I_OPQ:    begin d_srcA = d_p0.ra; d_srcB = d_p0.rb; d_dstE = d_p0.rb; end
      I_CALL:   begin d_srcB = RRSP; d_dstE = RRSP; end
      I_RET:    begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; end
      I_PUSHQ:  begin d_srcA = d_p0.ra; d_srcB = RRSP; d_dstE = RRSP; end
      I_POPQ:   begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; d_dstM = d_p0.ra; end
      default:  ;
    endcase
  end

  regfile_2w2r #(.RSP_INIT(RSP_INIT)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .val_a (rf_a),
    .val_b (rf_b),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM)
  );

  always_comb begin
    d_valA = fwd_sel(d_srcA, rf_a, e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    // Call and jump carry the return / fall-through address in valA.
    if (d_p0.icode == I_CALL || d_p0.icode == I_JXX) d_valA = d_p0.valp;
    d_valB = fwd_sel(d_srcB, rf_b, e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam logic [63:0] TB_RSP = 64'h100;
  localparam logic [3:0]  NONE   = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [2:0]  f_stat;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  D_icode, D_ifun;
  logic [2:0]  D_stat;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  logic [63:0] m_rf [15];
  logic [3:0]  m_icode, m_ifun, m_rA, m_rB;
  logic [63:0] m_valC, m_valP;
  logic [2:0]  m_stat;

  always #5 clk = ~clk;

  decode_stage #(.RSP_INIT(TB_RSP)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
    .D_stall(D_stall), .D_bubble(D_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_stat(D_stat),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
`ifdef RSP_RESET_EN
    m_rf[4] = TB_RSP;
`endif
    m_icode = 4'h1; m_ifun = 4'h0; m_rA = NONE; m_rB = NONE;
    m_valC = 64'h0; m_valP = 64'h0; m_stat = 3'd1;
  endtask

  function automatic logic [3:0] exp_srcA();
    if (m_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return m_rA;
    if (m_icode inside {4'h9, 4'hB}) return 4'h4;
    return NONE;
  endfunction

  function automatic logic [3:0] exp_srcB();
    if (m_icode inside {4'h4, 4'h5, 4'h6}) return m_rB;
    if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return NONE;
  endfunction

  function automatic logic [3:0] exp_dstE();
    if (m_icode inside {4'h2, 4'h3, 4'h6}) return m_rB;
    if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return NONE;
  endfunction

  function automatic logic [3:0] exp_dstM();
    if (m_icode inside {4'h5, 4'hB}) return m_rA;
    return NONE;
  endfunction

  function automatic logic [63:0] exp_operand(input logic [3:0] src);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    if (src == NONE) return 64'h0;
    ids[0] = e_dstE; vals[0] = e_valE;
    ids[1] = M_dstM; vals[1] = m_valM;
    ids[2] = M_dstE; vals[2] = M_valE;
    ids[3] = W_dstM; vals[3] = W_valM;
    ids[4] = W_dstE; vals[4] = W_valE;
    for (int k = 0; k < 5; k++) if (ids[k] == src) return vals[k];
    return m_rf[src];
  endfunction

  task automatic check_all(input string tag);
    logic [63:0] ea;
    ea = (m_icode == 4'h7 || m_icode == 4'h8) ? m_valP : exp_operand(exp_srcA());
    chk({tag, ".D_icode"}, {60'h0, D_icode}, {60'h0, m_icode});
    chk({tag, ".D_ifun"},  {60'h0, D_ifun},  {60'h0, m_ifun});
    chk({tag, ".D_stat"},  {61'h0, D_stat},  {61'h0, m_stat});
    chk({tag, ".D_valC"},  D_valC, m_valC);
    chk({tag, ".D_valP"},  D_valP, m_valP);
    chk({tag, ".d_srcA"},  {60'h0, d_srcA}, {60'h0, exp_srcA()});
    chk({tag, ".d_srcB"},  {60'h0, d_srcB}, {60'h0, exp_srcB()});
    chk({tag, ".d_dstE"},  {60'h0, d_dstE}, {60'h0, exp_dstE()});
    chk({tag, ".d_dstM"},  {60'h0, d_dstM}, {60'h0, exp_dstM()});
    chk({tag, ".d_valA"},  d_valA, ea);
    chk({tag, ".d_valB"},  d_valB, exp_operand(exp_srcB()));
  endtask

  // Advance one clock: model absorbs the inputs present at the edge.
  task automatic tick();
    if (W_dstE != NONE) m_rf[W_dstE] = W_valE;
    if (W_dstM != NONE) m_rf[W_dstM] = W_valM;
    if (!D_stall) begin
      if (D_bubble) begin
        m_icode = 4'h1; m_ifun = 4'h0; m_rA = NONE; m_rB = NONE;
        m_valC = 64'h0; m_valP = 64'h0; m_stat = 3'd1;
      end else begin
        m_icode = f_icode; m_ifun = f_ifun; m_rA = f_rA; m_rB = f_rB;
        m_valC = f_valC; m_valP = f_valP; m_stat = f_stat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb;
    f_valC = vc; f_valP = vp; f_stat = 3'd1;
  endtask

  function automatic logic [3:0] rnd_id();
    return ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom_range(0, 14));
  endfunction

  initial begin
    rst_n = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    no_fwd();
    fetch(4'h1, NONE, NONE, 64'h0, 64'h0);
    model_reset();
    #12;

    // Reset state
    chk("rst.D_icode", {60'h0, D_icode}, 64'h1);
    chk("rst.d_srcA",  {60'h0, d_srcA}, {60'h0, NONE});
    chk("rst.d_srcB",  {60'h0, d_srcB}, {60'h0, NONE});
    chk("rst.d_valA",  d_valA, 64'h0);
    chk("rst.d_valB",  d_valB, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("idle");

    // pop in D reads %rsp reset value
    fetch(4'hB, 4'h0, NONE, 64'h0, 64'h2);
    tick();
`ifdef RSP_RESET_EN
    chk("pop.rsp", d_valB, TB_RSP);
`else
    chk("pop.rsp", d_valB, 64'h0);
`endif
    check_all("pop");

    // Write reg 2 while rrmovq %rdx,%rax enters D
    fetch(4'h2, 4'h2, 4'h0, 64'h0, 64'h4);
    W_dstE = 4'h2; W_valE = 64'h626;
    tick();
    no_fwd(); #1;
    chk("rrmov.srcA", {60'h0, d_srcA}, 64'h2);
    chk("rrmov.valA", d_valA, 64'h626);
    check_all("rrmov");

    // Execute forward beats memory forward
    fetch(4'h6, 4'h1, 4'h3, 64'h0, 64'h6);
    tick();
    e_dstE = 4'h1; e_valE = 64'h5; M_dstE = 4'h1; M_valE = 64'h7; #1;
    chk("opq.fwd_e", d_valA, 64'h5);
    check_all("opq_e");
    e_dstE = NONE; #1;
    chk("opq.fwd_M", d_valA, 64'h7);
    check_all("opq_M");

    // Dual write to reg 3: port M wins, and is forwarded meanwhile
    no_fwd();
    W_dstE = 4'h3; W_valE = 64'h9; W_dstM = 4'h3; W_valM = 64'h11; #1;
    chk("dual.fwd", d_valB, 64'h11);
    check_all("dual_fwd");
    tick();
    no_fwd(); #1;
    chk("dual.rf", d_valB, 64'h11);
    check_all("dual_rf");

    // Call: valA = valP regardless of forwards
    fetch(4'h8, NONE, NONE, 64'h40, 64'h20);
    tick();
    e_dstE = 4'h4; e_valE = 64'hdead; M_dstM = 4'h4; m_valM = 64'hbeef; #1;
    chk("call.valA", d_valA, 64'h20);
    chk("call.srcB", {60'h0, d_srcB}, 64'h4);
    chk("call.dstE", {60'h0, d_dstE}, 64'h4);
    check_all("call");
    no_fwd();

    // Stall holds, bubble clears, both -> hold
    D_stall = 1'b1; fetch(4'h6, 4'h1, 4'h2, 64'h0, 64'h8);
    tick();
    chk("stall.icode", {60'h0, D_icode}, 64'h8);
    check_all("stall");
    D_stall = 1'b0; D_bubble = 1'b1; f_stat = 3'd3;
    tick();
    chk("bubble.icode", {60'h0, D_icode}, 64'h1);
    chk("bubble.stat",  {61'h0, D_stat}, 64'h1);
    check_all("bubble");
    D_bubble = 1'b0; fetch(4'h3, NONE, 4'h5, 64'h77, 64'ha);
    tick();
    D_stall = 1'b1; D_bubble = 1'b1; fetch(4'h6, 4'h1, 4'h2, 64'h0, 64'hc);
    tick();
    chk("both.icode", {60'h0, D_icode}, 64'h3);
    check_all("both");
    D_stall = 1'b0; D_bubble = 1'b0;

    // Asynchronous reset between edges
    fetch(4'h2, 4'h3, 4'h1, 64'h0, 64'he);
    tick();
    #3; rst_n = 1'b0; #2;
    chk("arst.icode", {60'h0, D_icode}, 64'h1);
    model_reset();
    check_all("arst");
    rst_n = 1'b1;
    tick();
    chk("arst.rf3", d_valA, 64'h0);
    check_all("post_arst");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      f_icode = 4'($urandom_range(0, 15)); f_ifun = 4'($urandom_range(0, 15));
      f_rA = 4'($urandom_range(0, 15)); f_rB = 4'($urandom_range(0, 15));
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      f_stat = 3'($urandom_range(1, 4));
      D_stall  = ($urandom_range(0, 7) == 0);
      D_bubble = ($urandom_range(0, 7) == 0);
      e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
      W_dstE = rnd_id(); W_dstM = rnd_id();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom};
      #1;
      check_all("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
